// File: rtl/ikaopll_timing_sequencer_pkg.sv
// Shared slot-timing constants and sequencer state encoding for the OPLL timing slice.
package ikaopll_timing_pkg;

    localparam int SLOT_COUNT = 18;
    localparam int SLOT_WIDTH = 5;
    localparam int CH_WIDTH   = 4;

    localparam logic [SLOT_WIDTH-1:0] SLOT_LAST = SLOT_WIDTH'(SLOT_COUNT - 1);

    typedef enum logic [1:0] {
        HOLD,
        FLUSH,
        RUN
    } seq_state_e;

endpackage

// File: rtl/ikaopll_timing_sequencer_if.sv
// Timing bus fanned out from the sequencer to every slot pipeline in the core.
interface ikaopll_timing_sequencer_if
    import ikaopll_timing_pkg::*;
#(
    parameter int ENVCNT_WIDTH = 12
);

    logic                    o_PHI1PCEN_n;
    logic                    o_PHI1NCEN_n;
    logic [SLOT_WIDTH-1:0]   o_CYCLE;
    logic [CH_WIDTH-1:0]     o_CH;
    logic                    o_OP;
    logic                    o_CYCLE_00;
    logic                    o_CYCLE_17;
    logic [ENVCNT_WIDTH-1:0] o_ENVCNT;
    logic                    o_IC_n;

    modport master (
        output o_PHI1PCEN_n, o_PHI1NCEN_n, o_CYCLE, o_CH, o_OP,
               o_CYCLE_00, o_CYCLE_17, o_ENVCNT, o_IC_n
    );

    modport slave (
        input  o_PHI1PCEN_n, o_PHI1NCEN_n, o_CYCLE, o_CH, o_OP,
               o_CYCLE_00, o_CYCLE_17, o_ENVCNT, o_IC_n
    );

endinterface

// File: rtl/ikaopll_phi1_prescaler.sv
// Divides phiM ticks into registered, mutually exclusive phi1 positive/negative edge enables.
module ikaopll_phi1_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic i_EMUCLK,
    input  logic i_RST_n,
    input  logic i_TICK,
    output logic o_PHI1PCEN_n,
    output logic o_PHI1NCEN_n
);

    localparam int P_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [P_W-1:0] P_LAST = P_W'(PRESCALE - 1);
    localparam logic [P_W-1:0] P_HALF = P_W'(PRESCALE / 2 - 1);

    logic [P_W-1:0] p;

    // Enables are only ever low for the single EMUCLK after a qualifying tick.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            p            <= '0;
            o_PHI1PCEN_n <= 1'b1;
            o_PHI1NCEN_n <= 1'b1;
        end else if (i_TICK) begin
            p            <= (p == P_LAST) ? '0 : p + 1'b1;
            o_PHI1PCEN_n <= (p != P_LAST);
            o_PHI1NCEN_n <= (p != P_HALF);
        end else begin
            o_PHI1PCEN_n <= 1'b1;
            o_PHI1NCEN_n <= 1'b1;
        end
    end

endmodule

// File: rtl/ikaopll_timing_sequencer.sv
// OPLL master timing: phi1 enables, 18-slot sequencing, envelope counter, frame-aligned IC release.
// Optional build macro IKAOPLL_TIMING_FREEZE_EN adds i_FREEZE to suspend all phiM-tick activity.
module ikaopll_timing_sequencer
    import ikaopll_timing_pkg::*;
#(
    parameter int PRESCALE     = 4,
    parameter int ENVCNT_WIDTH = 12
) (
    input  logic i_EMUCLK,
    input  logic i_RST_n,
    input  logic i_PHIM_CEN_n,
    input  logic i_IC_n,
`ifdef IKAOPLL_TIMING_FREEZE_EN
    input  logic i_FREEZE,
`endif
    ikaopll_timing_sequencer_if.master tbus
);

    logic                    phim_tick;
    logic                    phi1p_cen_n;
    logic                    phi1n_cen_n;
    logic                    ic_s1;
    logic                    ic_s;
    logic [SLOT_WIDTH-1:0]   slot;
    logic [ENVCNT_WIDTH-1:0] envcnt;
    logic                    frame_wrap;
    seq_state_e              state_q;
    seq_state_e              state_d;

`ifdef IKAOPLL_TIMING_FREEZE_EN
    assign phim_tick = ~i_PHIM_CEN_n & ~i_FREEZE;
`else
    assign phim_tick = ~i_PHIM_CEN_n;
`endif

    ikaopll_phi1_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_EMUCLK     (i_EMUCLK),
        .i_RST_n      (i_RST_n),
        .i_TICK       (phim_tick),
        .o_PHI1PCEN_n (phi1p_cen_n),
        .o_PHI1NCEN_n (phi1n_cen_n)
    );

    assign frame_wrap = ~phi1p_cen_n & (slot == SLOT_LAST);

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            ic_s1 <= 1'b0;
            ic_s  <= 1'b0;
        end else if (phim_tick) begin
            ic_s1 <= i_IC_n;
            ic_s  <= ic_s1;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:    if (ic_s) state_d = FLUSH;
            FLUSH:   if (frame_wrap) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = HOLD;
        endcase
        if (!ic_s) state_d = HOLD;
    end

    // Slot stays pinned at 0 through the HOLD->FLUSH edge so the flush always spans a whole sweep.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            slot   <= '0;
            envcnt <= '0;
        end else begin
            if (!ic_s || state_q == HOLD) begin
                slot <= '0;
            end else if (!phi1p_cen_n) begin
                slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            end

            if (!ic_s) begin
                envcnt <= '0;
            end else if (frame_wrap) begin
                envcnt <= envcnt + 1'b1;
            end
        end
    end

    assign tbus.o_PHI1PCEN_n = phi1p_cen_n;
    assign tbus.o_PHI1NCEN_n = phi1n_cen_n;
    assign tbus.o_CYCLE      = slot;
    assign tbus.o_CH         = CH_WIDTH'(slot >> 1);
    assign tbus.o_OP         = slot[0];
    assign tbus.o_CYCLE_00   = (slot == '0);
    assign tbus.o_CYCLE_17   = (slot == SLOT_LAST);
    assign tbus.o_ENVCNT     = envcnt;
    assign tbus.o_IC_n       = (state_q == RUN);

endmodule

// File: tb/tb_ikaopll_timing_sequencer.sv
// Scoreboard bench for ikaopll_timing_sequencer; define IKAOPLL_TIMING_FREEZE_EN to cover i_FREEZE.
module tb_ikaopll_timing_sequencer;

    localparam int ENVW = 8;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic phim_cen_n = 1'b0;
    logic ic_n       = 1'b1;
`ifdef IKAOPLL_TIMING_FREEZE_EN
    logic freeze     = 1'b0;
`endif

    always #5 clk = ~clk;

    ikaopll_timing_sequencer_if #(.ENVCNT_WIDTH(ENVW)) tbus ();

    ikaopll_timing_sequencer #(
        .PRESCALE     (4),
        .ENVCNT_WIDTH (ENVW)
    ) dut (
        .i_EMUCLK     (clk),
        .i_RST_n      (rst_n),
        .i_PHIM_CEN_n (phim_cen_n),
        .i_IC_n       (ic_n),
`ifdef IKAOPLL_TIMING_FREEZE_EN
        .i_FREEZE     (freeze),
`endif
        .tbus         (tbus)
    );

    typedef struct packed {
        logic [4:0]      cyc;
        logic            icn;
        logic [ENVW-1:0] env;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   sb_en    = 1'b0;
    bit   gap_en   = 1'b1;
    bit   have_prev = 1'b0;
    int   exp_pgap = 4;
    int   exp_ngap = 2;
    int   since_p  = 0;
    int   since_n  = 0;
    int   div      = 1;
    bit   cen_hold = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input bit icn, input int env);
        exp_t e;
        e.cyc = 5'(c);
        e.icn = icn;
        e.env = ENVW'(env);
        sbq.push_back(e);
    endtask

    // phiM tick generator: every div-th EMUCLK, or held off entirely
    initial begin
        int dc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cen_hold) begin
                phim_cen_n = 1'b1;
            end else begin
                dc = (dc + 1 >= div) ? 0 : dc + 1;
                phim_cen_n = (dc != 0);
            end
        end
    end

    // Monitor: every phi1P enable is an output event; pop and compare when the scoreboard is armed
    always @(negedge clk) begin
        if (rst_n) begin
            since_p++;
            since_n++;
            if (!tbus.o_PHI1PCEN_n || !tbus.o_PHI1NCEN_n)
                chk("enables_exclusive", int'(!tbus.o_PHI1PCEN_n && !tbus.o_PHI1NCEN_n), 0);
            if (!tbus.o_PHI1PCEN_n) begin
                if (gap_en && have_prev) begin
                    chk("phi1p_period", since_p, exp_pgap);
                    chk("phi1n_lead", since_n, exp_ngap);
                end
                have_prev = gap_en;
                since_p = 0;
                if (sb_en) begin
                    chk("sb_nonempty", int'(sbq.size() != 0), 1);
                    if (sbq.size() != 0) begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("sb_cycle", int'(tbus.o_CYCLE), int'(e.cyc));
                        chk("sb_ch", int'(tbus.o_CH), int'(e.cyc >> 1));
                        chk("sb_op", int'(tbus.o_OP), int'(e.cyc[0]));
                        chk("sb_cycle00", int'(tbus.o_CYCLE_00), int'(e.cyc == 5'd0));
                        chk("sb_cycle17", int'(tbus.o_CYCLE_17), int'(e.cyc == 5'd17));
                        chk("sb_ic_n", int'(tbus.o_IC_n), int'(e.icn));
                        chk("sb_envcnt", int'(tbus.o_ENVCNT), int'(e.env));
                    end
                end
            end
            if (!tbus.o_PHI1NCEN_n) since_n = 0;
        end
    end

    task automatic wait_pulse(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!tbus.o_PHI1PCEN_n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, int'(ok), 1);
    endtask

    task automatic wait_cycle_pulse(input int c, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!tbus.o_PHI1PCEN_n && int'(tbus.o_CYCLE) == c) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, int'(ok), 1);
    endtask

    // Release IC one EMUCLK after a phi1P pulse so the flush sweep is phase-aligned (72 ticks to release)
    task automatic release_ic(input bit full, input string name);
        int n;
        wait_pulse({name, "_align"});
        @(posedge clk);
        #1;
        if (full) begin
            for (int c = 0; c < 18; c++) push(c, 1'b0, 0);
            push(0, 1'b1, 1);
            sb_en = 1'b1;
        end
        ic_n = 1'b1;
        if (full) begin
            n = 0;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk);
                #1;
                n++;
                if (tbus.o_IC_n) break;
            end
            chk({name, "_ic_rise_ticks"}, n, 72);
            chk({name, "_ic_rise_slot"}, int'(tbus.o_CYCLE), 0);
            wait_pulse({name, "_post"});
            @(posedge clk);
            #1;
            chk({name, "_sb_drained"}, sbq.size(), 0);
            sb_en = 1'b0;
        end
    endtask

    initial begin
        int n, first, cnt, bad, rises, c0;
        bit prev, risen;

        // Reset state
        rst_n = 1'b0;
        ic_n  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pcen_n", int'(tbus.o_PHI1PCEN_n), 1);
        chk("rst_ncen_n", int'(tbus.o_PHI1NCEN_n), 1);
        chk("rst_cycle", int'(tbus.o_CYCLE), 0);
        chk("rst_ch", int'(tbus.o_CH), 0);
        chk("rst_op", int'(tbus.o_OP), 0);
        chk("rst_cycle00", int'(tbus.o_CYCLE_00), 1);
        chk("rst_cycle17", int'(tbus.o_CYCLE_17), 0);
        chk("rst_envcnt", int'(tbus.o_ENVCNT), 0);
        chk("rst_ic_n", int'(tbus.o_IC_n), 0);

        // First sweep out of reset: 18 flush slots then release at slot 0
        for (int c = 0; c < 18; c++) push(c, 1'b0, 0);
        push(0, 1'b1, 1);
        sb_en = 1'b1;
        rst_n = 1'b1;
        n = 0;
        first = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!tbus.o_PHI1PCEN_n && first == 0) first = n;
            if (tbus.o_IC_n) break;
        end
        chk("first_phi1p_tick", first, 4);
        chk("boot_ic_rise_ticks", n, 73);
        wait_pulse("boot_post");
        @(posedge clk);
        #1;
        chk("boot_sb_drained", sbq.size(), 0);

        // 256 frames with an 8-bit envelope counter: it wraps through 0 back to 1
        for (int c = 1; c < 18; c++) push(c, 1'b1, 1);
        for (int f = 1; f < 256; f++)
            for (int c = 0; c < 18; c++) push(c, 1'b1, (1 + f) % 256);
        push(0, 1'b1, 257 % 256);
        rises = 0;
        prev  = tbus.o_CYCLE_17;
        for (int i = 0; i < 4608 * 4 + 200; i++) begin
            @(posedge clk);
            #1;
            if (tbus.o_CYCLE_17 && !prev) rises++;
            prev = tbus.o_CYCLE_17;
            if (sbq.size() == 0) break;
        end
        chk("frames_sb_drained", sbq.size(), 0);
        chk("cycle17_once_per_frame", rises, 256);
        chk("envcnt_after_wrap", int'(tbus.o_ENVCNT), 1);
        sb_en = 1'b0;

        // IC pulse at slot 9
        wait_cycle_pulse(9, "t3_find_slot9");
        ic_n = 1'b0;
        cnt = 0;
        bad = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (!tbus.o_PHI1PCEN_n) cnt++;
            if (i == 2) begin
                chk("t3_sync_latency_slot", int'(tbus.o_CYCLE), 10);
                chk("t3_sync_latency_ic_n", int'(tbus.o_IC_n), 1);
            end
            if (i == 3) begin
                chk("t3_forced_slot", int'(tbus.o_CYCLE), 0);
                chk("t3_forced_env", int'(tbus.o_ENVCNT), 0);
                chk("t3_forced_ic_n", int'(tbus.o_IC_n), 0);
            end
            if (i >= 3 && (tbus.o_CYCLE != 5'd0 || tbus.o_ENVCNT != '0 || tbus.o_IC_n)) bad++;
        end
        chk("t3_hold_enables_run", cnt, 2);
        chk("t3_hold_stable", bad, 0);
        release_ic(1'b1, "t3");

        // Drop IC during FLUSH at slot 12
        ic_n = 1'b0;
        repeat (12) @(posedge clk);
        release_ic(1'b0, "t4a");
        wait_cycle_pulse(12, "t4_find_slot12");
        ic_n = 1'b0;
        risen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (tbus.o_IC_n) risen = 1'b1;
        end
        chk("t4_ic_never_rose", int'(risen), 0);
        chk("t4_slot_held", int'(tbus.o_CYCLE), 0);
        release_ic(1'b1, "t4b");

        // phiM tick every 3rd EMUCLK
        gap_en = 1'b0;
        div = 3;
        repeat (40) @(posedge clk);
        exp_pgap = 12;
        exp_ngap = 6;
        gap_en = 1'b1;
        for (int i = 0; i < 30; i++) wait_pulse("t5_div3_pulse");
        gap_en = 1'b0;

        // phiM enable held off: everything frozen
        cen_hold = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        c0 = int'(tbus.o_CYCLE);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (int'(tbus.o_CYCLE) != c0 || !tbus.o_PHI1PCEN_n || !tbus.o_PHI1NCEN_n) bad++;
        end
        chk("t5_phim_held_frozen", bad, 0);
        cen_hold = 1'b0;
        div = 1;
        exp_pgap = 4;
        exp_ngap = 2;
        repeat (20) @(posedge clk);
        gap_en = 1'b1;
        for (int i = 0; i < 3; i++) wait_pulse("t5_div1_pulse");

`ifdef IKAOPLL_TIMING_FREEZE_EN
        // Freeze at slot 5 for 50 EMUCLK, prescaler phase preserved
        gap_en = 1'b0;
        wait_cycle_pulse(4, "t6_find_slot4");
        @(posedge clk);
        #1;
        chk("t6_start_slot", int'(tbus.o_CYCLE), 5);
        freeze = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (tbus.o_CYCLE != 5'd5 || !tbus.o_PHI1PCEN_n || !tbus.o_PHI1NCEN_n) bad++;
        end
        freeze = 1'b0;
        chk("t6_frozen", bad, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!tbus.o_PHI1PCEN_n) break;
        end
        chk("t6_resume_phase", n, 3);
        chk("t6_resume_slot", int'(tbus.o_CYCLE), 5);
        @(posedge clk);
        #1;
        chk("t6_next_slot", int'(tbus.o_CYCLE), 6);
        repeat (8) @(posedge clk);
        gap_en = 1'b1;
`endif

        // Asynchronous reset in the middle of a phi1P pulse
        wait_pulse("t7_align");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_pcen_n", int'(tbus.o_PHI1PCEN_n), 1);
        chk("t7_async_ncen_n", int'(tbus.o_PHI1NCEN_n), 1);
        chk("t7_async_cycle", int'(tbus.o_CYCLE), 0);
        chk("t7_async_cycle00", int'(tbus.o_CYCLE_00), 1);
        chk("t7_async_envcnt", int'(tbus.o_ENVCNT), 0);
        chk("t7_async_ic_n", int'(tbus.o_IC_n), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #3000000;
        n_err++;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
